// File: rtl/spi_pixel_master_pkg.sv
// Shared definitions for the SPI pixel initiator: phase encodings, byte geometry
// and the SPI mode 0 clock polarity agreed with the vga receiver.
package spi_pixel_master_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned TICK_W        = 8;
  localparam int unsigned BYTE_CNT_W    = 3;
  localparam int unsigned BIT_CNT_W     = 3;

  // SPI mode 0: clock idles low, slave samples on the rising edge.
  localparam logic SCLK_IDLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_TRAIL  = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

endpackage

// File: rtl/spi_phase_tick.sv
// Half-period divider: strobes once every HALF_CYCLES cycles and restarts its
// count whenever the owning FSM changes state.
module spi_phase_tick
  import spi_pixel_master_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end_c,
  output logic phase_end_next_c
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(HALF_CYCLES - 1);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] count_d;

  always_comb begin
    count_d = count_q + TICK_W'(1);
    if (restart || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase_end_c      = (count_q == LAST);
  // Lets the owner register a flag that lines up with the final cycle of a phase.
  assign phase_end_next_c = (count_d == LAST);

endmodule

// File: rtl/spi_pixel_master.sv
// SPI mode 0 initiator: accepts one parallel frame per handshake and sends it MSB
// first, one chip-select window per byte, with a one-phase gap between bytes.
module spi_pixel_master
  import spi_pixel_master_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 3,
  parameter int unsigned HALF_CYCLES = 1
) (
  input  logic                                 MainClk,
  input  logic                                 Reset,
  input  logic [FRAME_BYTES*BITS_PER_BYTE-1:0] InData,
  input  logic                                 InValid,
  output logic                                 InReady,
  output logic                                 Busy,
  output logic                                 FrameDone,
  output logic                                 Sclk,
  output logic                                 Mosi,
  output logic                                 CSel
);

  localparam int unsigned         DATA_W    = FRAME_BYTES * BITS_PER_BYTE;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_BYTES - 1);
  localparam logic [BIT_CNT_W-1:0]  TOP_BIT   = BIT_CNT_W'(BITS_PER_BYTE - 1);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    csel_q, csel_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    restart_c;
  logic                    phase_end_c;
  logic                    phase_end_next_c;

  spi_phase_tick #(
    .HALF_CYCLES (HALF_CYCLES)
  ) u_phase_tick (
    .clk              (MainClk),
    .rst              (Reset),
    .restart          (restart_c),
    .phase_end_c      (phase_end_c),
    .phase_end_next_c (phase_end_next_c)
  );

  // Next-state, datapath and pin values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = SCLK_IDLE;
    mosi_d     = 1'b0;
    csel_d     = 1'b1;
    ready_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          shift_d    = InData;
          byte_cnt_d = '0;
          state_d    = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (phase_end_c) begin
          bit_cnt_d = TOP_BIT;
          state_d   = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (phase_end_c) begin
          state_d = ST_BIT_HI;
        end
      end
      ST_BIT_HI: begin
        if (phase_end_c) begin
          if (bit_cnt_q == '0) begin
            state_d = ST_TRAIL;
          end else begin
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            state_d   = ST_BIT_LO;
          end
        end
      end
      ST_TRAIL: begin
        if (phase_end_c) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (phase_end_c) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_IDLE;
          end else begin
            // Seven shifts happened inside the byte; the eighth exposes the next one.
            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            state_d    = ST_LEAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
      end
      ST_LEAD: begin
        csel_d = 1'b0;
      end
      ST_BIT_LO: begin
        csel_d = 1'b0;
        mosi_d = shift_d[DATA_W-1];
      end
      ST_BIT_HI: begin
        csel_d = 1'b0;
        sclk_d = ~SCLK_IDLE;
        mosi_d = mosi_q;
      end
      ST_TRAIL: begin
        csel_d = 1'b0;
        mosi_d = mosi_q;
      end
      default: begin
        csel_d = 1'b1;
      end
    endcase
  end

  assign restart_c = (state_d != state_q);
  assign done_d    = (state_d == ST_GAP) && (byte_cnt_d == LAST_BYTE) && phase_end_next_c;

  always_ff @(posedge MainClk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      csel_q     <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      csel_q     <= csel_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign InReady   = ready_q;
  assign Busy      = ~ready_q;
  assign FrameDone = done_q;
  assign Sclk      = sclk_q;
  assign Mosi      = mosi_q;
  assign CSel      = csel_q;

endmodule

// File: tb/tb_spi_pixel_master.sv
// Bench for spi_pixel_master: three parameter sets, each with an SPI slave model
// and a scoreboard of expected bytes and FrameDone times.
module tb_spi_pixel_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int unsigned FB       = (g == 2) ? 1 : 3;
    localparam int unsigned HC       = (g == 1) ? 4 : 1;
    localparam int unsigned DW       = FB * 8;
    localparam int unsigned N        = FB * 19 * HC;
    localparam int unsigned ABORT_AT = ((FB > 1) ? 19 * HC : 0) + 7 * HC;
    localparam logic [23:0] FRAME_A  = (g == 1) ? 24'h030303 : (g == 2) ? 24'h0000A5 : 24'hC0C0C0;
    localparam logic [23:0] FRAME_B  = 24'h030303;

    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready, busy, frame_done, sclk, mosi, csel;
    logic          armed    = 1'b0;
    logic [7:0]    exp_q[$];
    int            done_q[$];

    spi_pixel_master #(
      .FRAME_BYTES (FB),
      .HALF_CYCLES (HC)
    ) dut (
      .MainClk   (clk),
      .Reset     (rst),
      .InData    (in_data),
      .InValid   (in_valid),
      .InReady   (in_ready),
      .Busy      (busy),
      .FrameDone (frame_done),
      .Sclk      (sclk),
      .Mosi      (mosi),
      .CSel      (csel)
    );

    // Slave model, protocol checks and handshake model, sampled on the falling edge.
    initial begin : monitor
      logic       p_sclk, p_csel, p_mosi, abort, model_ready;
      logic [7:0] rx;
      int         bits, low_run, busy_until;
      p_sclk = 1'b0; p_csel = 1'b1; p_mosi = 1'b0; abort = 1'b0;
      rx = '0; bits = 0; low_run = 0; busy_until = 0;
      forever begin
        @(negedge clk);
        if (armed) begin
          model_ready = (cyc >= busy_until);
          chk($sformatf("c%0d InReady", g), in_ready, model_ready);
          chk($sformatf("c%0d Busy", g), busy, !in_ready);
          if (csel) chk($sformatf("c%0d Sclk while CSel high", g), sclk, 0);
          if (sclk && !p_sclk && !csel) begin
            chk($sformatf("c%0d Mosi set before rise", g), mosi, p_mosi);
            rx = {rx[6:0], mosi};
            bits++;
          end
          if (sclk && p_sclk) chk($sformatf("c%0d Mosi stable while Sclk high", g), mosi, p_mosi);
          if (!csel) low_run++;
          if (csel && !p_csel) begin
            if (abort) begin
              abort = 1'b0;
            end else begin
              chk($sformatf("c%0d rising edges per window", g), bits, 8);
              chk($sformatf("c%0d CSel low length", g), low_run, 18 * HC);
              if (exp_q.size() == 0) chk($sformatf("c%0d expected byte available", g), 0, 1);
              else chk($sformatf("c%0d received byte", g), rx, exp_q.pop_front());
            end
            bits = 0;
            low_run = 0;
          end
          if (frame_done) begin
            if (done_q.size() == 0) chk($sformatf("c%0d unexpected FrameDone", g), 1, 0);
            else chk($sformatf("c%0d FrameDone cycle", g), cyc, done_q.pop_front());
          end
          if (rst) begin
            exp_q.delete();
            done_q.delete();
            busy_until = cyc + 1;
            if (!csel) abort = 1'b1;
          end else if (model_ready && in_valid) begin
            for (int b = int'(FB) - 1; b >= 0; b--) exp_q.push_back(in_data[b*8 +: 8]);
            done_q.push_back(cyc + int'(N));
            busy_until = cyc + int'(N) + 1;
          end
        end
        p_sclk = sclk;
        p_csel = csel;
        p_mosi = mosi;
      end
    end

    initial begin : driver
      repeat (2) step();
      chk($sformatf("c%0d reset InReady", g), in_ready, 1);
      chk($sformatf("c%0d reset Busy", g), busy, 0);
      chk($sformatf("c%0d reset Sclk", g), sclk, 0);
      chk($sformatf("c%0d reset CSel", g), csel, 1);
      chk($sformatf("c%0d reset Mosi", g), mosi, 0);
      chk($sformatf("c%0d reset FrameDone", g), frame_done, 0);
      rst   = 1'b0;
      armed = 1'b1;

      // Single directed frame.
      in_data  = DW'(FRAME_A);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < int'(N) + 10 && !in_ready; k++) step();
      chk($sformatf("c%0d idle after frame A", g), in_ready, 1);

      // Back-to-back with InValid held, then ignored pulses while busy.
      in_data  = DW'(FRAME_A);
      in_valid = 1'b1;
      step();
      in_data = DW'(FRAME_B);
      for (int k = 0; k < int'(N) + 10 && !in_ready; k++) step();
      step();
      in_valid = 1'b0;
      repeat (N / 3) begin
        in_valid = 1'($urandom_range(1));
        in_data  = DW'($urandom);
        step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < int'(N) + 10 && !in_ready; k++) step();
      chk($sformatf("c%0d idle after back-to-back", g), in_ready, 1);

      // Reset in the middle of a bit.
      in_data  = DW'($urandom);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (ABORT_AT) step();
      rst = 1'b1;
      step();
      chk($sformatf("c%0d abort Sclk", g), sclk, 0);
      chk($sformatf("c%0d abort CSel", g), csel, 1);
      chk($sformatf("c%0d abort Mosi", g), mosi, 0);
      chk($sformatf("c%0d abort InReady", g), in_ready, 1);
      chk($sformatf("c%0d abort FrameDone", g), frame_done, 0);
      rst = 1'b0;

      // Randomised offers.
      repeat (2500) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = DW'($urandom);
        step();
      end
      in_valid = 1'b0;
      repeat (N + 4) step();
      chk($sformatf("c%0d bytes outstanding", g), exp_q.size(), 0);
      chk($sformatf("c%0d FrameDone outstanding", g), done_q.size(), 0);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
    chk("all configurations finished", n_done, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
